gate_pipe: RTL and testbench
============================

GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (1..64).
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages (1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream operand beat valid.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 op  input  3  operation select, sampled with the beat.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B (ignored for unary ops).
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 y  output  WIDTH  bitwise result.
REQ-013 out_op  output  3  op code that produced y.
REQ-014 op_count  output  16  count of completed output handshakes.

Function
REQ-015 Op encoding: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 BUF a.
REQ-016 Result computed bitwise, per bit i from a[i], b[i]; no carry, no width growth.
REQ-017 Input handshake: beat accepted when in_valid && in_ready at a rising edge.
REQ-018 Output handshake: beat retired when out_valid && out_ready at a rising edge.
REQ-019 Stage k holds {valid, op, y}; stage k loads when empty or when stage k+1 (or the output) takes its contents the same cycle.
REQ-020 in_ready = stage-1 empty OR stage 1 advancing this cycle; combinational from out_ready through the chain.
REQ-021 Result computed before stage-1 register; later stages pass through unchanged.
REQ-022 Latency: accepted beat appears on y/out_valid exactly STAGES cycles later when out_ready held high.
REQ-023 Throughput: one beat per cycle sustained with out_ready high; no bubbles inserted.
REQ-024 Backpressure: out_ready low holds y, out_op, out_valid stable until handshake; no beat lost or duplicated.
REQ-025 Full: all STAGES valid and out_ready low -> in_ready low.
REQ-026 Simultaneous accept and retire on a full pipe: both occur; occupancy unchanged.
REQ-027 Empty pipe: out_valid low; y holds last retired value (not required to be zero after first beat).
REQ-028 op_count increments by 1 per output handshake; saturates at 16'hFFFF (no wrap).
REQ-029 Order preserved: beats exit in acceptance order.

Reset
REQ-030 rst_n low clears all stage valid bits, y to 0, out_op to 0, op_count to 0 immediately, without waiting for clk.
REQ-031 In-flight beats at reset assertion are discarded, not retired, not counted.
REQ-032 in_ready shall be 1 and out_valid 0 in reset; first accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package gate_pkg holds the 3-bit op typedef and the eight op-code constants.
REQ-034 One sub-module gate_pipe_stage: a single valid/ready register slice parameterised by payload width, instantiated STAGES times by generate.
REQ-035 Op decode/compute logic lives in gate_pipe only, as one combinational block.

Verification (WIDTH=8, STAGES=2)
REQ-036 Reset: rst_n low mid-stream with 2 beats in flight -> out_valid 0, op_count 0, y 8'h00 asynchronously; no stray beat after release.
REQ-037 All ops: a=8'hC5, b=8'h3A, op 000..111 back-to-back, out_ready=1 -> y = 3A, 00, FF, FF, FF, 00, 00, C5 each 2 cycles after accept, op_count=8.
REQ-038 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 accepts; y stable; release -> both beats exit in order, no loss.
REQ-039 Simultaneous: full pipe, out_ready=1 and in_valid=1 same cycle -> one accept and one retire, in_ready stays 1.
REQ-040 Saturation: force 65 540 handshakes -> op_count holds 16'hFFFF.
REQ-041 Random: 10 000 beats, random in_valid/out_ready -> scoreboard match on y and out_op, order preserved, latency ≥2 cycles.

Source files
------------

// File: rtl/gate_pkg.sv
// Purpose: shared op-code type and constants for the gate_pipe bitwise pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOT  = 3'b000;  // ~a
  localparam op_t OP_AND  = 3'b001;  // a & b
  localparam op_t OP_OR   = 3'b010;  // a | b
  localparam op_t OP_XOR  = 3'b011;  // a ^ b
  localparam op_t OP_NAND = 3'b100;  // ~(a & b)
  localparam op_t OP_NOR  = 3'b101;  // ~(a | b)
  localparam op_t OP_XNOR = 3'b110;  // ~(a ^ b)
  localparam op_t OP_BUF  = 3'b111;  // a

endpackage

// File: rtl/gate_pipe_stage.sv
// Purpose: one valid/ready register slice carrying a DW-bit payload.
// Latency: 1 cycle from accept to out_vld.
// Backpressure: in_rdy = empty or draining this cycle (combinational from out_rdy).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_vld/in_rdy     upstream handshake, in_dat payload
//   out_vld/out_rdy   downstream handshake, out_dat payload
module gate_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  logic          vld_q;
  logic [DW-1:0] dat_q;

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  // Payload only loads on an accepted beat, so an emptied slice keeps the
  // last value that passed through it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      if (in_rdy) begin
        vld_q <= in_vld;
      end
      if (in_vld && in_rdy) begin
        dat_q <= in_dat;
      end
    end
  end

endmodule

// File: rtl/gate_pipe.sv
// Purpose: bitwise logic-op unit (NOT/AND/OR/XOR/NAND/NOR/XNOR/BUF) behind a STAGES-deep valid/ready pipe.
// Latency: STAGES cycles from accept to out_valid with out_ready high; one beat per cycle sustained.
// Backpressure: out_ready low stalls the pipe in place; in_ready falls once every stage is full.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand beat handshake; op, a, b sampled with it
//   out_valid/out_ready     result beat handshake; y result, out_op producing op
//   op_count                saturating count of output handshakes
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       out_op,
  output logic [15:0]      op_count
);

  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] y;
  } beat_t;

  localparam int DW = $bits(beat_t);

  beat_t res_c;

  // The result is formed once, ahead of the first register; later stages
  // only move it along.
  always_comb begin
    res_c.op = op;
    res_c.y  = ~a;
    case (op)
      OP_NOT:  res_c.y = ~a;
      OP_AND:  res_c.y = a & b;
      OP_OR:   res_c.y = a | b;
      OP_XOR:  res_c.y = a ^ b;
      OP_NAND: res_c.y = ~(a & b);
      OP_NOR:  res_c.y = ~(a | b);
      OP_XNOR: res_c.y = ~(a ^ b);
      OP_BUF:  res_c.y = a;
    endcase
  end

  // Each stage gets its own handshake nets so the ready chain, which runs
  // back from out_ready, is a set of distinct signals rather than bits of
  // one vector feeding each other.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic  s_in_rdy;
    logic  s_vld;
    beat_t s_dat;
    logic  s_up_vld;
    beat_t s_up_dat;
    logic  s_dn_rdy;

    if (k == 0) begin : g_head
      assign s_up_vld = in_valid;
      assign s_up_dat = res_c;
    end else begin : g_body
      assign s_up_vld = g_st[k-1].s_vld;
      assign s_up_dat = g_st[k-1].s_dat;
    end

    if (k == STAGES - 1) begin : g_tail
      assign s_dn_rdy = out_ready;
    end else begin : g_mid
      assign s_dn_rdy = g_st[k+1].s_in_rdy;
    end

    gate_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (s_up_vld),
      .in_rdy  (s_in_rdy),
      .in_dat  (s_up_dat),
      .out_vld (s_vld),
      .out_rdy (s_dn_rdy),
      .out_dat (s_dat)
    );
  end

  assign in_ready  = g_st[0].s_in_rdy;
  assign out_valid = g_st[STAGES-1].s_vld;
  assign y         = g_st[STAGES-1].s_dat.y;
  assign out_op    = g_st[STAGES-1].s_dat.op;

  // Saturating handshake counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_gate_pipe.sv
// Purpose: self-checking bench for gate_pipe (WIDTH=8, STAGES=2) using a scoreboard queue.
// Latency: checks exact STAGES latency with out_ready high, at least STAGES otherwise.
// Backpressure: random and directed out_ready stalls, output hold and no loss/duplication.
module tb_gate_pipe;
  import gate_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       out_op;
  logic [15:0]      op_count;

  gate_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .out_op   (out_op),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] y;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          hs_total = 0;
  logic [15:0] model_cnt = 16'd0;
  bit          exact_lat = 1'b0;
  bit          hold_vld = 1'b0;
  logic [7:0]  hold_y;
  logic [2:0]  hold_op;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Truth-table model: bit i of the result is tt[{a[i], b[i]}].
  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
    logic [3:0] tt;
    logic [7:0] r;
    case (o)
      3'd0:    tt = 4'b0011;
      3'd1:    tt = 4'b1000;
      3'd2:    tt = 4'b1110;
      3'd3:    tt = 4'b0110;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{aa[i], bb[i]}];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled at the falling edge, where inputs and outputs
  // are stable for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      check("op_count", op_count, model_cnt);
      if (hold_vld) begin
        check("hold_vld", out_valid, 1);
        check("hold_y", y, hold_y);
        check("hold_op", out_op, hold_op);
      end
      hold_vld = out_valid && !out_ready;
      hold_y   = y;
      hold_op  = out_op;
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("y", y, e.y);
          check("out_op", out_op, e.op);
          if (exact_lat) check("lat_exact", cyc - e.acc, STAGES);
          else           check("lat_min", (cyc - e.acc) >= STAGES, 1);
        end
        hs_total++;
        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      end
    end
  end

  task automatic push_exp(input logic [2:0] o, input logic [7:0] ey);
    exp_t e;
    e.op  = o;
    e.y   = ey;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // One cycle of stimulus: drive, observe handshake at the falling edge,
  // then step past the rising edge.
  task automatic drive_cycle(input bit v, input logic [2:0] o, input logic [7:0] aa,
                             input logic [7:0] bb, input bit r, input logic [7:0] ey,
                             output bit acc);
    in_valid  = v;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = r;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) push_exp(o, ey);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_out_vld", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tbl [8];
    logic [2:0] ro;
    logic [7:0] ra, rb;
    bit         acc;
    int         acc_n;
    int         guard;

    tbl = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;

    // Reset state
    #2;
    check("rst_out_vld", out_valid, 0);
    check("rst_in_rdy", in_ready, 1);
    check("rst_y", y, 0);
    check("rst_out_op", out_op, 0);
    check("rst_cnt", op_count, 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;

    // All eight ops back-to-back, exact latency
    exact_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ro = 3'(i);
      drive_cycle(1'b1, ro, 8'hC5, 8'h3A, 1'b1, tbl[i], acc);
      check("allops_acc", acc, 1);
    end
    drain();
    exact_lat = 1'b0;
    check("allops_cnt", op_count, 8);

    // Reset mid-stream with two beats in flight
    for (int i = 0; i < 2; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      drive_cycle(1'b1, OP_XOR, ra, rb, 1'b0, model(OP_XOR, ra, rb), acc);
    end
    in_valid = 1'b0;
    check("pre_rst_vld", out_valid, 1);
    check("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_cnt = 16'd0;
    hs_total  = 0;
    #1;
    check("arst_out_vld", out_valid, 0);
    check("arst_cnt", op_count, 0);
    check("arst_y", y, 0);
    check("arst_in_rdy", in_ready, 1);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stray", out_valid, 0);
    end
    @(posedge clk); #1;

    // Backpressure: five cycles of out_ready low with in_valid high
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      ro = 3'($urandom_range(7)); ra = 8'($urandom); rb = 8'($urandom);
      drive_cycle(1'b1, ro, ra, rb, 1'b0, model(ro, ra, rb), acc);
      acc_n += int'(acc);
    end
    check("bp_accepts", acc_n, 2);
    check("bp_full_rdy", in_ready, 0);
    drain();

    // Simultaneous accept and retire on a full pipe
    for (int i = 0; i < 2; i++) begin
      ro = 3'($urandom_range(7)); ra = 8'($urandom); rb = 8'($urandom);
      drive_cycle(1'b1, ro, ra, rb, 1'b0, model(ro, ra, rb), acc);
    end
    ro = OP_NAND; ra = 8'h5A; rb = 8'h0F;
    in_valid = 1'b1; op = ro; a = ra; b = rb; out_ready = 1'b1;
    @(negedge clk);
    check("sim_in_rdy", in_ready, 1);
    check("sim_out_vld", out_valid, 1);
    if (in_ready) push_exp(ro, model(ro, ra, rb));
    @(posedge clk); #1;
    check("sim_occ_vld", out_valid, 1);
    check("sim_occ_sb", sb.size(), 2);
    check("sim_rdy_after", in_ready, 1);
    drain();

    // Random traffic
    acc_n = 0;
    guard = 0;
    while (acc_n < 10000 && guard < 40000) begin
      ro = 3'($urandom_range(7)); ra = 8'($urandom); rb = 8'($urandom);
      drive_cycle($urandom_range(3) != 0, ro, ra, rb, $urandom_range(3) != 0,
                  model(ro, ra, rb), acc);
      acc_n += int'(acc);
      guard++;
    end
    check("rand_beats", acc_n, 10000);
    drain();

    // Saturation of op_count
    guard = 0;
    while (hs_total < 65540 && guard < 70000) begin
      ro = 3'($urandom_range(7)); ra = 8'($urandom); rb = 8'($urandom);
      drive_cycle(1'b1, ro, ra, rb, 1'b1, model(ro, ra, rb), acc);
      guard++;
    end
    drain();
    check("sat_hs", hs_total >= 65540, 1);
    check("sat_cnt", op_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
